// File: rtl/sw_pio_poller.sv
// sw_pio_poller: Avalon-MM initiator that polls a switch PIO edge-capture
// register, clears pending edges, reads the live switch levels and hands
// one event per poll to the effect-select logic over a valid/ready stream.
module sw_pio_poller #(
    parameter int WIDTH         = 10,
    parameter int POLL_INTERVAL = 1000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [WIDTH-1:0] event_data,
    output logic [WIDTH-1:0] event_edges,
    output logic [15:0]      event_count
);

    localparam int             CW          = $clog2(POLL_INTERVAL);
    localparam logic [CW-1:0]  RELOAD      = CW'(POLL_INTERVAL - 1);
    localparam logic [1:0]     ADDR_DATA   = 2'd0;
    localparam logic [1:0]     ADDR_EDGE   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_EDGE,
        WAIT_EDGE,
        CLR,
        RD_DATA,
        WAIT_DATA,
        OUT
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;

    logic [1:0]        address_reg, address_next;
    logic              chipselect_reg, chipselect_next;
    logic              write_n_reg, write_n_next;
    logic [31:0]       writedata_reg, writedata_next;
    logic              valid_reg, valid_next;
    logic [WIDTH-1:0]  data_reg, data_next;
    logic [WIDTH-1:0]  edges_reg, edges_next;
    logic [15:0]       evcount_reg, evcount_next;

    // Only the low WIDTH bits of the slave response carry switch information.
    logic [WIDTH-1:0]  sample;
    assign sample = avm_readdata[WIDTH-1:0];

    // Next-state, poll counter and event capture; bus outputs are decoded
    // from the next state so they appear registered in the matching state.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        data_next       = data_reg;
        edges_next      = edges_reg;
        evcount_next    = evcount_reg;
        address_next    = ADDR_DATA;
        chipselect_next = 1'b0;
        write_n_next    = 1'b1;
        writedata_next  = 32'h0000_0000;
        valid_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (count_reg == '0) begin
                    state_next = RD_EDGE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            RD_EDGE: begin
                state_next = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (sample == '0) begin
                    state_next = IDLE;
                end else begin
                    edges_next = sample;
                    state_next = CLR;
                end
            end
            CLR: begin
                state_next = RD_DATA;
            end
            RD_DATA: begin
                state_next = WAIT_DATA;
            end
            WAIT_DATA: begin
                data_next  = sample;
                state_next = OUT;
            end
            OUT: begin
                // Polling stays suspended while the consumer stalls; the PIO
                // keeps OR-ing new edges so they show up on the next poll.
                if (valid_reg && event_ready) begin
                    evcount_next = evcount_reg + 16'd1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The counter only runs in IDLE; everywhere else it sits at the
        // reload value so every entry into IDLE starts a full interval.
        if (state_reg != IDLE) begin
            count_next = RELOAD;
        end

        case (state_next)
            RD_EDGE: begin
                chipselect_next = 1'b1;
                address_next    = ADDR_EDGE;
            end
            WAIT_EDGE: begin
                address_next    = ADDR_EDGE;
            end
            CLR: begin
                chipselect_next = 1'b1;
                write_n_next    = 1'b0;
                address_next    = ADDR_EDGE;
                writedata_next  = 32'hFFFF_FFFF;
            end
            RD_DATA: begin
                chipselect_next = 1'b1;
                address_next    = ADDR_DATA;
            end
            WAIT_DATA: begin
                address_next    = ADDR_DATA;
            end
            OUT: begin
                valid_next      = 1'b1;
            end
            default: begin
                address_next    = ADDR_DATA;
            end
        endcase
    end

    // State and poll counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= RELOAD;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Registered bus strobes and event stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_reg    <= ADDR_DATA;
            chipselect_reg <= 1'b0;
            write_n_reg    <= 1'b1;
            writedata_reg  <= 32'h0000_0000;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            edges_reg      <= '0;
            evcount_reg    <= 16'd0;
        end else begin
            address_reg    <= address_next;
            chipselect_reg <= chipselect_next;
            write_n_reg    <= write_n_next;
            writedata_reg  <= writedata_next;
            valid_reg      <= valid_next;
            data_reg       <= data_next;
            edges_reg      <= edges_next;
            evcount_reg    <= evcount_next;
        end
    end

    assign avm_address    = address_reg;
    assign avm_chipselect = chipselect_reg;
    assign avm_write_n    = write_n_reg;
    assign avm_writedata  = writedata_reg;
    assign event_valid    = valid_reg;
    assign event_data     = data_reg;
    assign event_edges    = edges_reg;
    assign event_count    = evcount_reg;

endmodule

// File: tb/tb_sw_pio_poller.sv
// Bench for sw_pio_poller: a behavioural edge-capture PIO slave, a scoreboard
// of expected events checked on every accepted handshake, and directed
// bus-timing checks.
module tb_sw_pio_poller;

    localparam int W  = 10;
    localparam int PI = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [W-1:0] event_data;
    logic [W-1:0] event_edges;
    logic [15:0] event_count;

    // Slave model state and stimulus knobs.
    logic [W-1:0] in_port  = '0;
    logic [W-1:0] edge_cap = '0;
    logic [W-1:0] inject   = '0;
    logic [31:0]  junk     = '0;

    typedef struct packed {
        logic [W-1:0] edges;
        logic [W-1:0] data;
    } ev_t;
    ev_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int cyc = 0;

    sw_pio_poller #(.WIDTH(W), .POLL_INTERVAL(PI)) dut (
        .clk            (clk),
        .reset          (reset),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_data     (event_data),
        .event_edges    (event_edges),
        .event_count    (event_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: edge capture accumulates, writing 1s clears, reads registered.
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
            edge_cap <= (edge_cap & ~avm_writedata[W-1:0]) | inject;
        else
            edge_cap <= edge_cap | inject;
        if (avm_chipselect && avm_write_n) begin
            case (avm_address)
                2'd0:    avm_readdata <= {{(32-W){1'b0}}, in_port};
                2'd3:    avm_readdata <= {{(32-W){1'b0}}, edge_cap} | junk;
                default: avm_readdata <= '0;
            endcase
        end else begin
            avm_readdata <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count writes and compare every accepted event against the scoreboard.
    always @(negedge clk) begin
        if (!reset && avm_chipselect && !avm_write_n) n_writes <= n_writes + 1;
        if (!reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'd1, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("sb_edges", 32'(event_edges), 32'(e.edges));
                check("sb_data", 32'(event_data), 32'(e.data));
                $display("event accepted: edges=%03h data=%03h count=%0d", event_edges, event_data, event_count);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cs(output int at);
        bit found;
        found = 1'b0;
        at = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (avm_chipselect) begin
                found = 1'b1;
                at = cyc;
            end
        end
        if (!found) begin
            check("wait_cs_timeout", 32'd0, 32'd1);
            at = cyc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int e;
        int a;
        int exp_writes;
        exp_writes = 0;

        // Reset, idle polling with no edges pending.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_wn", 32'(avm_write_n), 32'd1);
        reset = 1'b0;
        c0 = cyc;
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_data", 32'(event_data), 32'd0);
        check("rst_edges", 32'(event_edges), 32'd0);
        check("rst_count", 32'(event_count), 32'd0);
        for (int k = 1; k < PI; k++) begin
            step();
            check("idle_cs", 32'(avm_chipselect), 32'd0);
        end
        step();
        check("poll1_cycle", 32'(cyc - c0), 32'd8);
        check("poll1_cs", 32'(avm_chipselect), 32'd1);
        check("poll1_addr", 32'(avm_address), 32'd3);
        check("poll1_wn", 32'(avm_write_n), 32'd1);
        $display("poll at cycle %0d addr=%0d", cyc - c0, avm_address);
        wait_cs(e);
        check("poll2_cycle", 32'(e - c0), 32'd18);
        wait_cs(e);
        check("poll3_cycle", 32'(e - c0), 32'd28);
        check("no_writes", 32'(n_writes), 32'd0);

        // Single event, consumer ready.
        step();
        step();
        in_port = 10'h3A5;
        inject = 10'h005;
        exp_q.push_back('{edges: 10'h005, data: 10'h3A5});
        step();
        inject = '0;
        event_ready = 1'b1;
        wait_cs(e);
        check("ev_rd_cycle", 32'(e - c0), 32'd38);
        check("ev_rd_addr", 32'(avm_address), 32'd3);
        check("ev_rd_wn", 32'(avm_write_n), 32'd1);
        step();
        check("ev_wait_cs", 32'(avm_chipselect), 32'd0);
        check("ev_wait_addr", 32'(avm_address), 32'd3);
        step();
        check("ev_clr_cs", 32'(avm_chipselect), 32'd1);
        check("ev_clr_wn", 32'(avm_write_n), 32'd0);
        check("ev_clr_addr", 32'(avm_address), 32'd3);
        check("ev_clr_wdata", avm_writedata, 32'hFFFF_FFFF);
        step();
        check("ev_rdd_cs", 32'(avm_chipselect), 32'd1);
        check("ev_rdd_wn", 32'(avm_write_n), 32'd1);
        check("ev_rdd_addr", 32'(avm_address), 32'd0);
        check("ev_rdd_wdata", avm_writedata, 32'd0);
        step();
        check("ev_waitd_cs", 32'(avm_chipselect), 32'd0);
        step();
        check("ev_valid", 32'(event_valid), 32'd1);
        check("ev_edges", 32'(event_edges), 32'h005);
        check("ev_data", 32'(event_data), 32'h3A5);
        check("ev_count0", 32'(event_count), 32'd0);
        step();
        check("ev_valid_drop", 32'(event_valid), 32'd0);
        check("ev_count1", 32'(event_count), 32'd1);
        exp_writes++;
        check("ev_writes", 32'(n_writes), 32'(exp_writes));

        // Stalled consumer; switch 2 toggles while stalled.
        event_ready = 1'b0;
        inject = 10'h005;
        exp_q.push_back('{edges: 10'h005, data: 10'h3A5});
        step();
        inject = '0;
        wait_cs(e);
        repeat (5) step();
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", 32'(event_valid), 32'd1);
            check("stall_edges", 32'(event_edges), 32'h005);
            check("stall_data", 32'(event_data), 32'h3A5);
            check("stall_cs", 32'(avm_chipselect), 32'd0);
            if (i == 5) begin
                in_port = 10'h3A1;
                inject = 10'h004;
                exp_q.push_back('{edges: 10'h004, data: 10'h3A1});
            end
            if (i == 6) inject = '0;
            step();
        end
        event_ready = 1'b1;
        step();
        a = cyc;
        check("stall_accept_valid", 32'(event_valid), 32'd0);
        check("stall_accept_count", 32'(event_count), 32'd2);
        exp_writes++;
        wait_cs(e);
        check("repoll_cycle", 32'(e - a), 32'd8);
        repeat (5) step();
        check("sw2_valid", 32'(event_valid), 32'd1);
        check("sw2_edges", 32'(event_edges), 32'h004);
        check("sw2_data", 32'(event_data), 32'h3A1);
        step();
        check("sw2_valid_drop", 32'(event_valid), 32'd0);
        check("sw2_count", 32'(event_count), 32'd3);
        exp_writes++;
        check("sw2_writes", 32'(n_writes), 32'(exp_writes));

        // Upper readdata bits must not trigger an event.
        junk = 32'hFFFF_FC00;
        wait_cs(e);
        step();
        step();
        check("junk_no_clr_cs", 32'(avm_chipselect), 32'd0);
        check("junk_no_clr_wn", 32'(avm_write_n), 32'd1);
        wait_cs(a);
        check("junk_period", 32'(a - e), 32'd10);
        check("junk_addr", 32'(avm_address), 32'd3);
        junk = '0;
        check("junk_writes", 32'(n_writes), 32'(exp_writes));
        check("junk_no_valid", 32'(event_valid), 32'd0);

        // Reset in the middle of the clear write.
        inject = 10'h001;
        exp_q.push_back('{edges: 10'h001, data: 10'h3A1});
        step();
        inject = '0;
        wait_cs(e);
        step();
        step();
        check("pre_rst_clr_wn", 32'(avm_write_n), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_cs", 32'(avm_chipselect), 32'd0);
        check("async_rst_wn", 32'(avm_write_n), 32'd1);
        check("async_rst_addr", 32'(avm_address), 32'd0);
        check("async_rst_wdata", avm_writedata, 32'd0);
        check("async_rst_count", 32'(event_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        c0 = cyc;
        wait_cs(e);
        check("post_rst_poll", 32'(e - c0), 32'd8);
        check("post_rst_count", 32'(event_count), 32'd0);
        repeat (5) step();
        check("post_rst_valid", 32'(event_valid), 32'd1);
        check("post_rst_edges", 32'(event_edges), 32'h001);
        step();
        check("post_rst_count1", 32'(event_count), 32'd1);
        exp_writes++;
        check("final_writes", 32'(n_writes), 32'(exp_writes));
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sw_pio_poller.md
# sw_pio_poller

Avalon-MM initiator that services the 10-bit switch input PIO (edge-capture type) so the audio pedalboard fabric gets switch events without Nios II involvement. It periodically reads the PIO edge-capture register. When any edge is pending, it clears the register, reads the live switch levels, and presents one event on a valid/ready stream to the effect-select logic. It sits between the switch PIO slave port and the effect-control FSM.

## Interface
- WIDTH, 10, number of switch bits used from readdata; 1..32
- POLL_INTERVAL, 1000, idle cycles between polls; must be >= 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avm_address  out  2  PIO register address (0 = data, 3 = edge capture)
- avm_chipselect  out  1  bus access strobe
- avm_write_n  out  1  active-low write
- avm_writedata  out  32  write data
- avm_readdata  in  32  PIO read data, registered by slave (1-cycle read latency)
- event_valid  out  1  event available
- event_ready  in  1  consumer accepts event
- event_data  out  WIDTH  switch levels read after clear
- event_edges  out  WIDTH  edge-capture bits that triggered the event
- event_count  out  16  accepted-event counter, wraps 0xFFFF -> 0x0000

## Operation
- All outputs are registered.
- States: IDLE, RD_EDGE, WAIT_EDGE, CLR, RD_DATA, WAIT_DATA, OUT.
- IDLE: bus idle (chipselect=0, write_n=1, address=0, writedata=0). A down-counter loaded with POLL_INTERVAL-1 decrements each cycle. At 0, the next state is RD_EDGE.
- RD_EDGE: chipselect=1, write_n=1, address=3.
- WAIT_EDGE: chipselect=0, address held at 3. Sample avm_readdata[WIDTH-1:0]; bits at WIDTH and above are ignored.
  - If the sample is zero: go to IDLE and reload the counter.
  - Otherwise: store the sample in event_edges and go to CLR.
- CLR: chipselect=1, write_n=0, address=3, writedata=32'hFFFFFFFF for one cycle.
- RD_DATA: chipselect=1, write_n=1, address=0.
- WAIT_DATA: chipselect=0, address held at 0. Sample avm_readdata[WIDTH-1:0] into event_data.
- OUT: event_valid=1, with event_data and event_edges held stable. No bus activity.
  - When event_valid & event_ready at a rising edge: event_valid drops next cycle, event_count increments, next state is IDLE with counter reloaded.
- Backpressure: while in OUT, polling is suspended. New edges accumulate (OR) in the PIO edge-capture register and are reported by the next poll; nothing is lost.
- Known loss window: an edge captured by the slave after the RD_EDGE sample and up to and including the CLR cycle is cleared without being reported. This window is 2 cycles per event and is accepted.
- Reset (asynchronous, any state): state goes to IDLE and the counter loads POLL_INTERVAL-1.
  - Reset values: chipselect=0, write_n=1, address=0, writedata=0, event_valid=0, event_data=0, event_edges=0, event_count=0.
  - The block does not clear the PIO registers on reset.

## Timing
- IDLE lasts exactly POLL_INTERVAL cycles.
- The first RD_EDGE strobe occurs in the cycle POLL_INTERVAL cycles after reset deasserts (cycle 0 = first cycle with reset low).
- Poll period with no pending edges: POLL_INTERVAL + 2 cycles.
- The edge-capture read is issued in cycle N; readdata is sampled in cycle N+1.
- Event path: RD_EDGE, WAIT_EDGE, CLR, RD_DATA, WAIT_DATA. event_valid is asserted in the 6th cycle after IDLE exits (RD_EDGE = cycle 1).
- chipselect is high for exactly one cycle per access. There are never back-to-back accesses to the same address without an intervening cycle, except CLR -> RD_DATA.
- If event_ready is already high when event_valid rises, the event is accepted in that same cycle, so event_valid is high for 1 cycle.

## Test plan
- Reset with POLL_INTERVAL=8, slave model returning 0 -> all outputs at reset values; first chipselect with address=3, write_n=1 at cycle 8; repeats every 10 cycles; no write ever issued.
- Slave edge_capture=0x005, in_port=0x3A5 -> read addr 3, write addr 3 data 0xFFFFFFFF, read addr 0; event_valid with event_edges=0x005, event_data=0x3A5; event_count goes 0 -> 1 on accept.
- Same event with event_ready held low for 20 cycles -> event_valid and data stable for all 20 cycles, chipselect stays 0; on ready, one-cycle accept and return to IDLE.
- avm_readdata=0xFFFFFC00 during WAIT_EDGE (WIDTH=10) -> treated as zero; no CLR, no event.
- Toggle switch 2 while OUT is stalled, then accept -> next poll reports edges bit 2 set; no event lost.
- Assert reset during CLR -> chipselect=0 and write_n=1 immediately (asynchronous); after release, first poll POLL_INTERVAL cycles later; event_count=0.
